multicycle_core: RTL and testbench

Parametrised multi-cycle successor to the single-cycle lab datapath. Accepts one 32-bit MIPS-subset instruction per handshake and executes it over 3–4 cycles through a registered FSM with internal register file and data memory. Supports R-type ALU ops, addi, lw and sw, with correct RegDst/ALUSrc/MemtoReg steering. Sits between the board switch/instruction source and the probe/7-segment display logic.

---
 rtl/multicycle_pkg.sv | 51 +++++
 rtl/multicycle_if.sv | 24 ++
 rtl/mc_alu.sv | 25 ++
 rtl/multicycle_core.sv | 146 ++++++++++++++
 tb/tb_multicycle_core.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_pkg.sv
// Shared types and decode helpers for the multi-cycle MIPS-subset core.
package multicycle_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StExec,
        StMem,
        StWb
    } state_e;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluSlt
    } alu_op_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;

    function automatic logic is_legal(logic [5:0] op, logic [5:0] funct);
        if (op == OpRtype) begin
            return (funct == FunctAdd) || (funct == FunctSub) || (funct == FunctAnd) ||
                   (funct == FunctOr) || (funct == FunctSlt);
        end
        return (op == OpAddi) || (op == OpLw) || (op == OpSw);
    endfunction

    // Non-R-type instructions all compute base + offset.
    function automatic alu_op_e alu_op_of(logic [5:0] op, logic [5:0] funct);
        if (op != OpRtype) return AluAdd;
        case (funct)
            FunctSub: return AluSub;
            FunctAnd: return AluAnd;
            FunctOr:  return AluOr;
            FunctSlt: return AluSlt;
            default:  return AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_if.sv
// Instruction handshake, retire status and probe bus of the multi-cycle core.
interface multicycle_if #(
    parameter int unsigned XLEN = 32
);
    logic [31:0]     instr;
    logic            instr_valid;
    logic            instr_ready;
    logic            done;
    logic            illegal;
    logic [XLEN-1:0] alu_result;
    logic [5:0]      probe_addr;
    logic [XLEN-1:0] probe_reg;
    logic [XLEN-1:0] probe_mem;

    modport master (
        output instr, instr_valid, probe_addr,
        input  instr_ready, done, illegal, alu_result, probe_reg, probe_mem
    );

    modport slave (
        input  instr, instr_valid, probe_addr,
        output instr_ready, done, illegal, alu_result, probe_reg, probe_mem
    );
endinterface

// File: rtl/mc_alu.sv
// Combinational ALU: add, sub, and, or, signed set-less-than.
module mc_alu
    import multicycle_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = '0;
        unique case (op_i)
            AluAdd:  result_o = a_i + b_i;
            AluSub:  result_o = a_i - b_i;
            AluAnd:  result_o = a_i & b_i;
            AluOr:   result_o = a_i | b_i;
            AluSlt:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle MIPS-subset core: IDLE/DECODE/EXEC/MEM/WB FSM with inline
// register file and data memory, plus side-effect-free probe ports.
module multicycle_core
    import multicycle_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREGS      = 32,
    parameter int unsigned DMEM_DEPTH = 64
) (
    input logic       clk,
    input logic       rst,
    multicycle_if.slave bus
);

    localparam int unsigned RIDX = $clog2(NREGS);
    localparam int unsigned MIDX = $clog2(DMEM_DEPTH);

    state_e          state_q, state_d;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] a_q, b_q, alu_out_q, mdr_q;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] dmem_q [DMEM_DEPTH];

    logic ir_en, ab_en, alu_en, mdr_en, reg_we, mem_we;
    logic instr_ready, done, illegal;

    logic [5:0]      op, funct;
    logic [4:0]      rs, rt, rd;
    logic [15:0]     imm;
    logic            is_rtype, is_lw, is_mem;
    logic [XLEN-1:0] sign_imm, alu_b, alu_y, wr_data;
    logic [RIDX-1:0] wr_idx;
    logic [MIDX-1:0] mem_idx;
    alu_op_e         alu_op;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign imm      = ir_q[15:0];
    assign funct    = ir_q[5:0];
    assign is_rtype = (op == OpRtype);
    assign is_lw    = (op == OpLw);
    assign is_mem   = is_lw || (op == OpSw);
    assign sign_imm = {{(XLEN-16){imm[15]}}, imm};
    assign alu_b    = is_rtype ? b_q : sign_imm;
    assign alu_op   = alu_op_of(op, funct);
    assign wr_idx   = is_rtype ? rd[RIDX-1:0] : rt[RIDX-1:0];
    assign wr_data  = is_lw ? mdr_q : alu_out_q;
    // Word addressing: byte offset bits are dropped, upper bits wrap.
    assign mem_idx  = alu_out_q[MIDX+1:2];

    mc_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .op_i    (alu_op),
        .a_i     (a_q),
        .b_i     (alu_b),
        .result_o(alu_y)
    );

    always_comb begin
        state_d     = state_q;
        ir_en       = 1'b0;
        ab_en       = 1'b0;
        alu_en      = 1'b0;
        mdr_en      = 1'b0;
        reg_we      = 1'b0;
        mem_we      = 1'b0;
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    ir_en   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_legal(op, funct)) begin
                    ab_en   = 1'b1;
                    state_d = StExec;
                end else begin
                    done    = 1'b1;
                    illegal = 1'b1;
                    state_d = StIdle;
                end
            end
            StExec: begin
                alu_en  = 1'b1;
                state_d = is_mem ? StMem : StWb;
            end
            StMem: begin
                if (is_lw) begin
                    mdr_en  = 1'b1;
                    state_d = StWb;
                end else begin
                    mem_we  = 1'b1;
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            StWb: begin
                reg_we  = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
            for (int i = 0; i < int'(DMEM_DEPTH); i++) dmem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (ir_en) ir_q <= bus.instr;
            if (ab_en) begin
                a_q <= regs_q[rs[RIDX-1:0]];
                b_q <= regs_q[rt[RIDX-1:0]];
            end
            if (alu_en) alu_out_q <= alu_y;
            if (mdr_en) mdr_q <= dmem_q[mem_idx];
            // Register 0 is never written, so it always reads as zero.
            if (reg_we && (wr_idx != '0)) regs_q[wr_idx] <= wr_data;
            if (mem_we) dmem_q[mem_idx] <= b_q;
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.done        = done;
    assign bus.illegal     = illegal;
    assign bus.alu_result  = alu_out_q;
    assign bus.probe_reg   = regs_q[RIDX'(bus.probe_addr)];
    assign bus.probe_mem   = dmem_q[MIDX'(bus.probe_addr)];

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboarded bench for multicycle_core: a reference model predicts each
// instruction's latency and effect, compared when the core retires it.
module tb_multicycle_core;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_if #(.XLEN(32)) bus ();

    multicycle_core #(
        .XLEN      (32),
        .NREGS     (32),
        .DMEM_DEPTH(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string       name;
        int          lat;
        bit          ill;
        int          kind;     // 0 none, 1 register write, 2 memory write
        int          idx;
        logic [31:0] old_val;
        logic [31:0] val;
        logic [31:0] alu;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [64];
    int          checks = 0;
    int          errors = 0;

    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101, F_SLT = 6'b101010;
    localparam logic [5:0] O_ADDI = 6'b001000, O_LW = 6'b100011, O_SW = 6'b101011;

    function automatic logic [31:0] enc_r(input logic [5:0] funct, input int rs, rt, rd);
        logic [4:0] s, t, d;
        s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
        return {6'b000000, s, t, d, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, rt,
                                          input logic [15:0] imm);
        logic [4:0] s, t;
        s = rs[4:0]; t = rt[4:0];
        return {op, s, t, imm};
    endfunction

    task automatic model_step(input string name, input logic [31:0] ins, output exp_t e);
        logic [31:0] a, b, sx, r, w;
        e = '{name: name, lat: 1, ill: 1'b1, kind: 0, idx: 0, old_val: 0, val: 0, alu: 0};
        a  = m_regs[ins[25:21]];
        b  = m_regs[ins[20:16]];
        sx = {{16{ins[15]}}, ins[15:0]};
        r  = 32'd0;
        if (ins[31:26] == 6'b000000) begin
            e.ill = 1'b0; e.lat = 3; e.kind = 1; e.idx = int'(ins[15:11]);
            case (ins[5:0])
                F_ADD:   r = a + b;
                F_SUB:   r = a - b;
                F_AND:   r = a & b;
                F_OR:    r = a | b;
                F_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: begin e.ill = 1'b1; e.lat = 1; e.kind = 0; end
            endcase
        end else if (ins[31:26] == O_ADDI || ins[31:26] == O_LW) begin
            r = a + sx;
            e.ill = 1'b0; e.kind = 1; e.idx = int'(ins[20:16]);
            e.lat = (ins[31:26] == O_LW) ? 4 : 3;
        end else if (ins[31:26] == O_SW) begin
            r = a + sx;
            e.ill = 1'b0; e.kind = 2; e.idx = int'(r[7:2]); e.lat = 3;
        end
        e.alu = r;
        if (e.kind == 1) begin
            w = (ins[31:26] == O_LW) ? m_mem[r[7:2]] : r;
            e.old_val = m_regs[e.idx];
            if (e.idx != 0) m_regs[e.idx] = w;
            e.val = m_regs[e.idx];
        end else if (e.kind == 2) begin
            e.old_val = m_mem[e.idx];
            m_mem[e.idx] = b;
            e.val = b;
        end
    endtask

    // Entered and left at a falling edge with the core idle.
    task automatic issue(input string name, input logic [31:0] ins, input bit hold,
                         input logic [31:0] alt);
        exp_t e, got;
        int   lat;
        model_step(name, ins, e);
        sb.push_back(e);
        bus.probe_addr = (e.kind == 0) ? 6'd1 : 6'(e.idx);
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before: got %b, expected 1", name, bus.instr_ready);
        end
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) bus.instr = alt;
        else begin bus.instr_valid = 1'b0; bus.instr = $urandom; end
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (bus.instr_ready !== 1'b0) begin
                    errors++; $display("FAIL %s ready_busy: got %b, expected 0", name, bus.instr_ready);
                end
            end
            if (bus.done === 1'b1) begin lat = k; break; end
        end
        got = sb.pop_front();
        checks++;
        if (lat != got.lat) begin
            errors++; $display("FAIL %s latency: got %0d, expected %0d (0 = timeout)", name, lat, got.lat);
        end
        checks++;
        if (bus.illegal !== got.ill) begin
            errors++; $display("FAIL %s illegal: got %b, expected %b", name, bus.illegal, got.ill);
        end
        if (got.kind != 0) begin
            checks++;
            if (bus.alu_result !== got.alu) begin
                errors++; $display("FAIL %s alu_result: got %h, expected %h", name, bus.alu_result, got.alu);
            end
            checks++;
            if ((got.kind == 1 ? bus.probe_reg : bus.probe_mem) !== got.old_val) begin
                errors++; $display("FAIL %s probe_old: got %h, expected %h", name,
                                   (got.kind == 1 ? bus.probe_reg : bus.probe_mem), got.old_val);
            end
        end
        if (hold) begin bus.instr_valid = 1'b0; bus.instr = $urandom; end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL %s done_pulse: got %b, expected 0", name, bus.done);
        end
        if (got.kind != 0) begin
            checks++;
            if ((got.kind == 1 ? bus.probe_reg : bus.probe_mem) !== got.val) begin
                errors++; $display("FAIL %s probe_new: got %h, expected %h", name,
                                   (got.kind == 1 ? bus.probe_reg : bus.probe_mem), got.val);
            end
        end
    endtask

    task automatic test_reset();
        int addrs [4] = '{0, 1, 31, 63};
        repeat (3) @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0 || bus.illegal !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: got ready=%b done=%b illegal=%b, expected 1 0 0",
                               bus.instr_ready, bus.done, bus.illegal);
        end
        checks++;
        if (bus.alu_result !== 32'd0) begin
            errors++; $display("FAIL reset_alu: got %h, expected 0", bus.alu_result);
        end
        foreach (addrs[i]) begin
            bus.probe_addr = 6'(addrs[i]);
            #1;
            checks++;
            if (bus.probe_reg !== 32'd0 || bus.probe_mem !== 32'd0) begin
                errors++; $display("FAIL reset_probe[%0d]: got reg=%h mem=%h, expected 0 0",
                                   addrs[i], bus.probe_reg, bus.probe_mem);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b, expected 1", bus.instr_ready);
        end
    endtask

    task automatic test_alu();
        int          idx [6] = '{1, 2, 3, 4, 5, 9};
        logic [31:0] want [6];
        want = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFF8, 32'd1, 32'd5};
        issue("addi_r1", enc_i(O_ADDI, 0, 1, 16'd5), 1'b0, 32'd0);
        issue("addi_r2", enc_i(O_ADDI, 0, 2, 16'hFFFD), 1'b0, 32'd0);
        issue("add_r3", enc_r(F_ADD, 1, 2, 3), 1'b0, 32'd0);
        issue("sub_r4", enc_r(F_SUB, 2, 1, 4), 1'b0, 32'd0);
        issue("slt_r5", enc_r(F_SLT, 2, 1, 5), 1'b0, 32'd0);
        issue("and_r9", enc_r(F_AND, 1, 2, 9), 1'b0, 32'd0);
        issue("or_r10", enc_r(F_OR, 1, 2, 10), 1'b0, 32'd0);
        foreach (idx[i]) begin
            bus.probe_addr = 6'(idx[i]);
            #1;
            checks++;
            if (bus.probe_reg !== want[i]) begin
                errors++; $display("FAIL alu_r%0d: got %h, expected %h", idx[i], bus.probe_reg, want[i]);
            end
        end
        bus.probe_addr = 6'd10;
        #1;
        checks++;
        if (bus.probe_reg !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL alu_r10: got %h, expected fffffffd", bus.probe_reg);
        end
    endtask

    task automatic test_mem();
        issue("sw_r1", enc_i(O_SW, 0, 1, 16'd8), 1'b0, 32'd0);
        bus.probe_addr = 6'd2;
        #1;
        checks++;
        if (bus.probe_mem !== 32'd5) begin
            errors++; $display("FAIL mem2_after_sw: got %h, expected 5", bus.probe_mem);
        end
        issue("lw_r6", enc_i(O_LW, 0, 6, 16'd8), 1'b0, 32'd0);
        issue("addi_r11", enc_i(O_ADDI, 0, 11, 16'd256), 1'b0, 32'd0);
        issue("lw_r12_wrap", enc_i(O_LW, 11, 12, 16'd8), 1'b0, 32'd0);
        bus.probe_addr = 6'd12;
        #1;
        checks++;
        if (bus.probe_reg !== 32'd5) begin
            errors++; $display("FAIL lw_wrap_r12: got %h, expected 5", bus.probe_reg);
        end
        issue("sw_r4_wrap", enc_i(O_SW, 11, 4, 16'd8), 1'b0, 32'd0);
        issue("lw_r13", enc_i(O_LW, 0, 13, 16'd8), 1'b0, 32'd0);
        bus.probe_addr = 6'd13;
        #1;
        checks++;
        if (bus.probe_reg !== 32'hFFFF_FFF8) begin
            errors++; $display("FAIL sw_wrap_r13: got %h, expected fffffff8", bus.probe_reg);
        end
    endtask

    task automatic test_r0_and_illegal();
        issue("addi_r0", enc_i(O_ADDI, 0, 0, 16'd7), 1'b0, 32'd0);
        issue("illegal_op", 32'hFC22_0000, 1'b0, 32'd0);
        issue("illegal_funct", enc_r(6'b000000, 1, 2, 1), 1'b0, 32'd0);
        bus.probe_addr = 6'd1;
        #1;
        checks++;
        if (bus.probe_reg !== 32'd5) begin
            errors++; $display("FAIL illegal_no_change_r1: got %h, expected 5", bus.probe_reg);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            issue($sformatf("chain_%0d", i), enc_i(O_ADDI, 15 + i, 16 + i, 16'($urandom)), 1'b0, 32'd0);
        end
        issue("chain_sub", enc_r(F_SUB, 19, 17, 20), 1'b0, 32'd0);
    endtask

    task automatic test_hold();
        issue("hold_add", enc_r(F_ADD, 1, 2, 14), 1'b1, enc_i(O_ADDI, 0, 7, 16'd99));
        bus.probe_addr = 6'd7;
        #1;
        checks++;
        if (bus.probe_reg !== 32'd0) begin
            errors++; $display("FAIL hold_no_second_accept_r7: got %h, expected 0", bus.probe_reg);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0) begin
                errors++; $display("FAIL hold_spurious_done[%0d]: got %b, expected 0", k, bus.done);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.probe_addr = 6'd8;
        bus.instr = enc_r(F_ADD, 1, 2, 8);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);   // decode
        @(negedge clk);   // exec
        rst = 1'b0;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL abort_ctrl: got ready=%b done=%b, expected 1 0",
                               bus.instr_ready, bus.done);
        end
        checks++;
        if (bus.probe_reg !== 32'd0) begin
            errors++; $display("FAIL abort_r8: got %h, expected 0", bus.probe_reg);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.probe_addr = 6'd1;
        #1;
        checks++;
        if (bus.probe_reg !== 32'd0 || bus.alu_result !== 32'd0) begin
            errors++; $display("FAIL abort_cleared: got r1=%h alu=%h, expected 0 0",
                               bus.probe_reg, bus.alu_result);
        end
        bus.probe_addr = 6'd2;
        #1;
        checks++;
        if (bus.probe_mem !== 32'd0) begin
            errors++; $display("FAIL abort_mem2: got %h, expected 0", bus.probe_mem);
        end
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
        @(negedge clk);
        issue("post_reset_addi", enc_i(O_ADDI, 0, 3, 16'd42), 1'b0, 32'd0);
    endtask

    initial begin
        bus.instr = 32'd0;
        bus.instr_valid = 1'b0;
        bus.probe_addr = 6'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
        test_reset();
        test_alu();
        test_mem();
        test_r0_and_illegal();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1);
    end

endmodule
